// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch controller: FSM state encoding
// and the PC-select codes driven onto {cPCMux, cPCSrc}.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PCSEL_PC4 = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JR  = 2'b10;

endpackage

// File: rtl/if_fetch_ctrl_sat_counter.sv
// Generic W-bit incrementer that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencing controller: post-reset hold, redirect arbitration
// (EX branch over ID jr), load-use stall, halt, and post-redirect bubbles.
//
// state | meaning
// HOLD  | post-reset fetch hold, PC frozen, IF/ID and ID/EX flushed
// RUN   | normal fetch, redirects / stalls / halt arbitrated
// FLUSH | extra IF/ID bubbles after a redirect (imem latency)
// HALT  | fetch stopped until reset
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int RESET_HOLD    = 2,
    parameter int EXTRA_BUBBLES = 0,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             iStallReq,
    input  logic             iJumpReg,
    input  logic             iBranchTaken,
    input  logic             iHalt,
    output logic             oPCSrc,
    output logic             oPCMux,
    output logic             oPCWrite,
    output logic             oIFIDWrite,
    output logic             oIFIDFlush,
    output logic             oIDEXFlush,
    output logic [1:0]       oState,
    output logic [CNT_W-1:0] oRedirects
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);
    localparam logic [1:0] BUB_LOAD  = 2'(EXTRA_BUBBLES);

    fetch_state_t state;
    logic [3:0]   hold_cnt;
    logic [1:0]   bub_cnt;
    logic [1:0]   pc_sel;
    logic         redirect;

    // Outputs decode straight from state and requests so a redirect
    // steers the PC on the same edge it is requested.
    always_comb begin
        pc_sel     = PCSEL_PC4;
        oPCWrite   = 1'b0;
        oIFIDWrite = 1'b0;
        oIFIDFlush = 1'b0;
        oIDEXFlush = 1'b0;
        redirect   = 1'b0;
        case (state)
            ST_HOLD: begin
                oIFIDFlush = 1'b1;
                oIDEXFlush = 1'b1;
            end
            ST_RUN: begin
                if (iBranchTaken) begin
                    pc_sel     = PCSEL_BR;
                    oPCWrite   = 1'b1;
                    oIFIDWrite = 1'b1;
                    oIFIDFlush = 1'b1;
                    oIDEXFlush = 1'b1;
                    redirect   = 1'b1;
                end else if (iJumpReg) begin
                    pc_sel     = PCSEL_JR;
                    oPCWrite   = 1'b1;
                    oIFIDWrite = 1'b1;
                    oIFIDFlush = 1'b1;
                    redirect   = 1'b1;
                end else if (iHalt) begin
                    oPCWrite = 1'b0;
                end else if (iStallReq) begin
                    oIDEXFlush = 1'b1;
                end else begin
                    oPCWrite   = 1'b1;
                    oIFIDWrite = 1'b1;
                end
            end
            ST_FLUSH: begin
                oPCWrite   = 1'b1;
                oIFIDWrite = 1'b1;
                oIFIDFlush = 1'b1;
                if (iBranchTaken) begin
                    pc_sel     = PCSEL_BR;
                    oIDEXFlush = 1'b1;
                    redirect   = 1'b1;
                end
            end
            ST_HALT: begin
                oIFIDFlush = 1'b1;
                oIDEXFlush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            bub_cnt  <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 4'd1;
                    if (hold_cnt == HOLD_LAST)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect) begin
                        if (EXTRA_BUBBLES > 0) begin
                            state   <= ST_FLUSH;
                            bub_cnt <= BUB_LOAD;
                        end
                    end else if (iHalt) begin
                        state <= ST_HALT;
                    end
                end
                ST_FLUSH: begin
                    if (redirect) begin
                        bub_cnt <= BUB_LOAD;
                    end else begin
                        bub_cnt <= bub_cnt - 2'd1;
                        if (bub_cnt == 2'd1)
                            state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .inc   (redirect),
        .count (oRedirects)
    );

    assign oPCMux = pc_sel[1];
    assign oPCSrc = pc_sel[0];
    assign oState = state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: two instances (with and without post-redirect
// bubbles) checked every cycle against a behavioural model of the rules.
module tb_if_fetch_ctrl;

    localparam int RH_A = 2, EB_A = 2, CW_A = 4;
    localparam int RH_B = 3, EB_B = 0, CW_B = 16;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic iStallReq = 1'b0, iJumpReg = 1'b0, iBranchTaken = 1'b0, iHalt = 1'b0;

    logic            a_pcsrc, a_pcmux, a_pcwrite, a_ifidw, a_ifidf, a_idexf;
    logic [1:0]      a_state;
    logic [CW_A-1:0] a_redir;
    logic            b_pcsrc, b_pcmux, b_pcwrite, b_ifidw, b_ifidf, b_idexf;
    logic [1:0]      b_state;
    logic [CW_B-1:0] b_redir;

    if_fetch_ctrl #(.RESET_HOLD(RH_A), .EXTRA_BUBBLES(EB_A), .CNT_W(CW_A)) dut_a (
        .Clk(Clk), .Reset(Reset), .iStallReq(iStallReq), .iJumpReg(iJumpReg),
        .iBranchTaken(iBranchTaken), .iHalt(iHalt), .oPCSrc(a_pcsrc), .oPCMux(a_pcmux),
        .oPCWrite(a_pcwrite), .oIFIDWrite(a_ifidw), .oIFIDFlush(a_ifidf),
        .oIDEXFlush(a_idexf), .oState(a_state), .oRedirects(a_redir));

    if_fetch_ctrl #(.RESET_HOLD(RH_B), .EXTRA_BUBBLES(EB_B), .CNT_W(CW_B)) dut_b (
        .Clk(Clk), .Reset(Reset), .iStallReq(iStallReq), .iJumpReg(iJumpReg),
        .iBranchTaken(iBranchTaken), .iHalt(iHalt), .oPCSrc(b_pcsrc), .oPCMux(b_pcmux),
        .oPCWrite(b_pcwrite), .oIFIDWrite(b_ifidw), .oIFIDFlush(b_ifidf),
        .oIDEXFlush(b_idexf), .oState(b_state), .oRedirects(b_redir));

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 hold, 1 run, 2 flush, 3 halt
    int p_rh[2] = '{RH_A, RH_B};
    int p_eb[2] = '{EB_A, EB_B};
    int p_cw[2] = '{CW_A, CW_B};
    int m_phase[2];
    int m_hold[2];
    int m_bub[2];
    int m_red[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_phase[k] = 0;
        m_hold[k]  = p_rh[k];
        m_bub[k]   = 0;
        m_red[k]   = 0;
    endtask

    task automatic model_redirect(input int k);
        int top;
        top = (1 << p_cw[k]) - 1;
        m_red[k] = (m_red[k] + 1 > top) ? top : m_red[k] + 1;
        if (p_eb[k] > 0) begin
            m_phase[k] = 2;
            m_bub[k]   = p_eb[k];
        end
    endtask

    // Advance the model across the next rising edge with current inputs.
    task automatic step_model(input int k);
        case (m_phase[k])
            0: begin
                m_hold[k]--;
                if (m_hold[k] == 0) m_phase[k] = 1;
            end
            1: begin
                if (iBranchTaken || iJumpReg) model_redirect(k);
                else if (iHalt) m_phase[k] = 3;
            end
            2: begin
                if (iBranchTaken) model_redirect(k);
                else begin
                    m_bub[k]--;
                    if (m_bub[k] == 0) m_phase[k] = 1;
                end
            end
            default: ;
        endcase
    endtask

    // care bits: [0] select, [1] pc write, [2] if/id write, [3] if/id flush, [4] id/ex flush
    task automatic expect_out(input int k, output logic [1:0] sel, output logic pcw,
                              output logic ifidw, output logic ifidf, output logic idexf,
                              output logic [4:0] care);
        sel = 2'b00; pcw = 0; ifidw = 0; ifidf = 0; idexf = 0; care = 5'b11111;
        if ((m_phase[k] == 1 || m_phase[k] == 2) && iBranchTaken) begin
            sel = 2'b01; pcw = 1; ifidf = 1; idexf = 1; care = 5'b11011;
        end else begin
            case (m_phase[k])
                0: begin ifidf = 1; idexf = 1; end
                1: begin
                    if (iJumpReg) begin
                        sel = 2'b10; pcw = 1; ifidf = 1; care = 5'b11011;
                    end else if (iHalt) begin
                        care = 5'b10110;
                    end else if (iStallReq) begin
                        idexf = 1; care = 5'b10110;
                    end else begin
                        pcw = 1; ifidw = 1;
                    end
                end
                2: begin pcw = 1; ifidf = 1; care = 5'b01011; end
                default: begin ifidf = 1; idexf = 1; care = 5'b11110; end
            endcase
        end
    endtask

    task automatic check_inst(input int k);
        logic [1:0] es, gs, gst;
        logic ep, ew, ef, ex, gp, gw, gf, gx;
        logic [4:0] care;
        logic [31:0] gr;
        string p;
        p = (k == 0) ? "A" : "B";
        if (k == 0) begin
            gs = {a_pcmux, a_pcsrc}; gp = a_pcwrite; gw = a_ifidw; gf = a_ifidf; gx = a_idexf;
            gst = a_state; gr = 32'(a_redir);
        end else begin
            gs = {b_pcmux, b_pcsrc}; gp = b_pcwrite; gw = b_ifidw; gf = b_ifidf; gx = b_idexf;
            gst = b_state; gr = 32'(b_redir);
        end
        expect_out(k, es, ep, ew, ef, ex, care);
        check({p, ".state"}, 32'(gst), 32'(m_phase[k]));
        check({p, ".redirects"}, gr, 32'(m_red[k]));
        check({p, ".sel_is_11"}, 32'(gs == 2'b11), 32'd0);
        if (care[0]) check({p, ".sel"}, 32'(gs), 32'(es));
        if (care[1]) check({p, ".pc_write"}, 32'(gp), 32'(ep));
        if (care[2]) check({p, ".ifid_write"}, 32'(gw), 32'(ew));
        if (care[3]) check({p, ".ifid_flush"}, 32'(gf), 32'(ef));
        if (care[4]) check({p, ".idex_flush"}, 32'(gx), 32'(ex));
    endtask

    task automatic cycle(input logic br, input logic jr, input logic halt, input logic stall);
        @(negedge Clk);
        iBranchTaken = br; iJumpReg = jr; iHalt = halt; iStallReq = stall;
        #1;
        check_inst(0); check_inst(1);
        step_model(0); step_model(1);
    endtask

    // Reset drops between edges to show it acts without a clock.
    task automatic do_reset(input int n);
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        model_reset(0); model_reset(1);
        check_inst(0); check_inst(1);
        repeat (n) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        iBranchTaken = 1'b1; iJumpReg = 1'b1; iHalt = 1'b1; iStallReq = 1'b1;
        #1;
        check_inst(0); check_inst(1);
        step_model(0); step_model(1);
    endtask

    initial begin
        model_reset(0); model_reset(1);
        do_reset(3);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("t1_run_state", 32'(a_state), 32'd1);
        check("t1_pc_write", 32'(a_pcwrite), 32'd1);

        cycle(0, 0, 0, 1);
        check("t2_stall_pcw", 32'(a_pcwrite), 32'd0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("t2_redirects", 32'(a_redir), 32'd0);

        cycle(1, 1, 1, 1);
        check("t3_sel", 32'({b_pcmux, b_pcsrc}), 32'd1);
        cycle(0, 0, 0, 0);
        check("t3_b_state", 32'(b_state), 32'd1);
        check("t3_b_redir", 32'(b_redir), 32'd1);
        repeat (3) cycle(0, 0, 0, 0);

        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        check("t4_flush_state", 32'(a_state), 32'd2);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("t4_back_run", 32'(a_state), 32'd1);

        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        check("t5_halt_state", 32'(a_state), 32'd3);
        cycle(0, 0, 0, 0);
        check("t5_halt_redir", 32'(a_redir), 32'd2);
        do_reset(2);
        check("t5_reset_redir", 32'(a_redir), 32'd0);
        repeat (3) cycle(0, 0, 0, 0);

        repeat (17) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("t6_sat_a", 32'(a_redir), 32'd15);
        check("t6_b_17", 32'(b_redir), 32'd17);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 2)
                do_reset(int'($urandom_range(3, 1)));
            else
                cycle($urandom_range(99) < 12, $urandom_range(99) < 12,
                      $urandom_range(99) < 3, $urandom_range(99) < 25);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequencing controller for the IF stage.
- Arbitrates PC redirect requests: jump-register resolved in ID, taken branch resolved in EX.
- Handles the ID load-use stall request and the ID halt request.
- Drives the IF stage PC-select controls (cPCSrc/cPCMux), PC write enable, IF/ID write/flush and ID/EX bubble.
- Adds a post-reset fetch hold and a saturating redirect counter for performance debug.

Parameters:
- RESET_HOLD, 2, cycles after reset release with PC frozen and IF/ID flushed (1..15).
- EXTRA_BUBBLES, 0, additional IF/ID flush cycles after any redirect, covering instruction-memory latency (0..3).
- CNT_W, 16, redirect counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low; all state cleared while low.
- iStallReq  in  1  load-use hazard from ID.
- iJumpReg  in  1  jr decoded in ID; target is the IF stage ReadReg1 input.
- iBranchTaken  in  1  branch taken in EX; target is the IF stage PCSumImm input.
- iHalt  in  1  halt decoded in ID.
- oPCSrc  out  1  to IF cPCSrc.
- oPCMux  out  1  to IF cPCMux.
- oPCWrite  out  1  PC register enable.
- oIFIDWrite  out  1  IF/ID enable.
- oIFIDFlush  out  1  IF/ID clear to NOP.
- oIDEXFlush  out  1  ID/EX clear to NOP.
- oState  out  2  FSM state, debug.
- oRedirects  out  CNT_W  accepted redirect count.

Behaviour:
- PC select encoding {oPCMux,oPCSrc}:
  - 00 = PC+4
  - 01 = PCSumImm (branch)
  - 10 = ReadReg1 (jr)
  - 11 is never driven.
- Outputs are combinational from state and inputs, so a redirect takes effect at the same clock edge it is requested. State and counters are registered.
- While Reset is low:
  - state = HOLD, hold counter = 0, oRedirects = 0.
  - oPCWrite = 0, oIFIDWrite = 0, oIFIDFlush = 1, oIDEXFlush = 1, select = 00.
- States: HOLD = 0, RUN = 1, FLUSH = 2, HALT = 3.
- HOLD:
  - oPCWrite = 0, oIFIDFlush = 1, oIDEXFlush = 1; all requests ignored.
  - Hold counter increments each cycle; move to RUN after RESET_HOLD cycles.
- RUN, priority from highest to lowest:
  1. iBranchTaken: select 01, oPCWrite = 1, oIFIDFlush = 1, oIDEXFlush = 1. Stall, jr and halt in the same cycle are discarded as wrong-path.
  2. iJumpReg: select 10, oPCWrite = 1, oIFIDFlush = 1, oIDEXFlush = 0. A simultaneous stall is ignored, because jr reads its register in ID and the hazard unit must not assert both.
  3. iHalt: oPCWrite = 0, oIFIDWrite = 0, oIDEXFlush = 0 (halt proceeds down the pipe); go to HALT.
  4. iStallReq: oPCWrite = 0, oIFIDWrite = 0, oIDEXFlush = 1; stay in RUN. There is no stall limit.
  5. Otherwise: select 00, oPCWrite = 1, oIFIDWrite = 1, flushes 0.
- On any accepted redirect (case 1 or 2):
  - oRedirects increments, saturating at all-ones.
  - If EXTRA_BUBBLES > 0, go to FLUSH with the bubble counter loaded to EXTRA_BUBBLES; otherwise stay in RUN.
- FLUSH:
  - Select 00, oPCWrite = 1, oIFIDFlush = 1.
  - iJumpReg, iHalt and iStallReq are ignored (ID holds a bubble).
  - iBranchTaken is still honoured as in case 1 and reloads the bubble counter.
  - Counter decrements; return to RUN when it reaches 0.
- HALT: oPCWrite = 0, oIFIDWrite = 0, oIFIDFlush = 1, oIDEXFlush = 1; all inputs ignored. Exit only via Reset.
- Reset asserted mid-stall, mid-flush or in HALT returns to HOLD immediately (asynchronous).

Decomposition:
- Shared processor package holds:
  - state encodings HOLD/RUN/FLUSH/HALT;
  - PC select constants PCSEL_PC4 = 2'b00, PCSEL_BR = 2'b01, PCSEL_JR = 2'b10.
- One natural sub-module, sat_counter: a generic CNT_W saturating incrementer used for oRedirects.
- FSM and output decode stay in if_fetch_ctrl.

Test Plan:
1. Reset low 3 cycles, then release, RESET_HOLD = 2: oPCWrite = 0 and oIFIDFlush = 1 for 2 edges, then oState = 1, oPCWrite = 1, select 00.
2. In RUN, iStallReq = 1 for 2 cycles: oPCWrite = 0, oIFIDWrite = 0, oIDEXFlush = 1 both cycles, then normal fetch; oRedirects stays 0.
3. iBranchTaken = 1 with iJumpReg = 1, iStallReq = 1, iHalt = 1 the same cycle: select 01, both flushes 1, oPCWrite = 1, oRedirects 0→1, next state RUN (not HALT).
4. iJumpReg = 1 alone, EXTRA_BUBBLES = 2: select 10 and oIFIDFlush = 1; then 2 cycles in FLUSH (oState = 2) with oIFIDFlush = 1 and iHalt ignored; then RUN.
5. iHalt = 1: next cycle oState = 3, oPCWrite = 0; a later iBranchTaken is ignored; Reset low returns to HOLD with oRedirects = 0.
6. CNT_W = 4, 17 redirects: oRedirects stops at 4'hF.
